// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// FSM that accepts a level change only after DEBOUNCE_CYCLES consecutive
// equal synchronized samples. All outputs come straight from registers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STABLE_LO | accepted level is 0, counter held at 0
// WAIT_HI   | sync2 went high, counting consecutive high samples
// STABLE_HI | accepted level is 1, counter held at 0
// WAIT_LO   | sync2 went low, counting consecutive low samples
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // The WAIT states are entered already holding the first sample, so the
    // last sample needed to accept arrives when the counter reads D-1.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic [7:0]           r_press_cnt;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_level_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;
    logic [7:0]           w_press_nxt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, counter and registered outputs; reset overrides acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= STABLE_LO;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_level     <= w_level_nxt;
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_press_cnt <= w_press_nxt;
        end
    end

    // Next-state, counter and output decisions from the synchronized sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_press_nxt = r_press_cnt;

        case (r_state)
            STABLE_LO: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_press_nxt = r_press_cnt + 8'd1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (r_sync2) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_rise    = r_rise;
    assign btn_fall    = r_fall;
    assign press_count = r_press_cnt;

endmodule
